// File: rtl/message_tx_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : message_tx_scheduler_if
// Brief    : Source-side handshake bundle for the shared message transmit path.
// Revision : 1.0 - initial release
// ============================================================================
interface message_tx_scheduler_if #(
  parameter int NUM_REQ = 4
);
  localparam int c_sel_w = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [c_sel_w-1:0] sel;
  logic               ld_shiftreg;
  logic               shift_en;
  logic               valid;
  logic [NUM_REQ-1:0] done;
  logic               busy;

  modport master (
    output req,
    input  gnt, sel, ld_shiftreg, shift_en, valid, done, busy
  );

  modport slave (
    input  req,
    output gnt, sel, ld_shiftreg, shift_en, valid, done, busy
  );
endinterface
`default_nettype wire

// File: rtl/message_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : message_tx_scheduler
// Brief    : Round-robin arbiter and bit/sample pacer for a shared message TX path.
// Revision : 1.0 - initial release
// ============================================================================
module message_tx_scheduler #(
  parameter int NUM_REQ         = 4,
  parameter int MSG_BITS        = 16,
  parameter int SAMPLES_PER_BIT = 1000,
  parameter int GAP_CYCLES      = 4
) (
  input  wire                     clk,
  input  wire                     reset,
  message_tx_scheduler_if.slave   bus
);

  localparam int c_sel_w = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [c_sel_w-1:0] r_grant_idx;
  logic [c_sel_w-1:0] r_rr_ptr;
  logic [9:0]         r_sample_cnt;
  logic [3:0]         r_bit_cnt;
  logic [9:0]         r_gap_cnt;

  logic               w_found;
  logic [c_sel_w-1:0] w_pick;
  int                 w_idx;
  logic               w_last_sample;
  logic               w_last_bit;
  logic               w_last_gap;
  logic               w_granted;
  logic [NUM_REQ-1:0] w_onehot;

  assign w_last_sample = (r_sample_cnt == 10'(SAMPLES_PER_BIT - 1));
  assign w_last_bit    = (r_bit_cnt == 4'(MSG_BITS - 1));
  assign w_last_gap    = (r_gap_cnt == 10'(GAP_CYCLES - 1));

  // Search starts one past the last served source so it gets lowest priority.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = (int'(r_rr_ptr) + 1 + i) % NUM_REQ;
      if (!w_found && bus.req[w_idx]) begin
        w_found = 1'b1;
        w_pick  = c_sel_w'(w_idx);
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_found) w_next_state = ST_LOAD;
      ST_LOAD: w_next_state = ST_SEND;
      ST_SEND: if (w_last_sample && w_last_bit)
                 w_next_state = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
      ST_GAP:  if (w_last_gap) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_grant_idx  <= '0;
      r_rr_ptr     <= c_sel_w'(NUM_REQ - 1);
      r_sample_cnt <= '0;
      r_bit_cnt    <= '0;
      r_gap_cnt    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_grant_idx <= w_pick;
            r_rr_ptr    <= w_pick;
          end
        end
        ST_LOAD: begin
          r_sample_cnt <= '0;
          r_bit_cnt    <= '0;
          r_gap_cnt    <= '0;
        end
        ST_SEND: begin
          if (w_last_sample) begin
            r_sample_cnt <= '0;
            r_bit_cnt    <= w_last_bit ? 4'd0 : r_bit_cnt + 4'd1;
          end else begin
            r_sample_cnt <= r_sample_cnt + 10'd1;
          end
        end
        ST_GAP: begin
          r_gap_cnt <= w_last_gap ? 10'd0 : r_gap_cnt + 10'd1;
        end
        default: ;
      endcase
    end
  end

  // Outputs decode only registered state so req never reaches them combinationally.
  assign w_granted = (r_state == ST_LOAD) || (r_state == ST_SEND);
  assign w_onehot  = NUM_REQ'(1) << r_grant_idx;

  assign bus.gnt         = w_granted ? w_onehot : '0;
  assign bus.sel         = w_granted ? r_grant_idx : '0;
  assign bus.ld_shiftreg = (r_state == ST_LOAD);
  assign bus.valid       = (r_state == ST_SEND);
  assign bus.shift_en    = (r_state == ST_SEND) && w_last_sample;
  assign bus.done        = ((r_state == ST_SEND) && w_last_sample && w_last_bit) ? w_onehot : '0;
  assign bus.busy        = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_message_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_message_tx_scheduler
// Brief    : Directed self-checking bench for message_tx_scheduler (4 req, 4 bits, 3 samples, gap 2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_message_tx_scheduler;

  localparam int c_num_req = 4;
  localparam int c_bits    = 4;
  localparam int c_spb     = 3;
  localparam int c_gap     = 2;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  message_tx_scheduler_if #(.NUM_REQ(c_num_req)) bus ();

  message_tx_scheduler #(
    .NUM_REQ        (c_num_req),
    .MSG_BITS       (c_bits),
    .SAMPLES_PER_BIT(c_spb),
    .GAP_CYCLES     (c_gap)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".gnt"},   32'(bus.gnt), 32'h0);
    chk({tag, ".valid"}, 32'(bus.valid), 32'h0);
    chk({tag, ".ld"},    32'(bus.ld_shiftreg), 32'h0);
    chk({tag, ".shift"}, 32'(bus.shift_en), 32'h0);
    chk({tag, ".done"},  32'(bus.done), 32'h0);
  endtask

  // Full message from the LOAD cycle through the following IDLE cycle.
  task automatic expect_msg(input string tag, input int idx, input logic [3:0] req_after);
    logic [3:0] oh;
    oh = 4'b0001 << idx;
    tick();
    chk({tag, ".load.gnt"}, 32'(bus.gnt), 32'(oh));
    chk({tag, ".load.sel"}, 32'(bus.sel), 32'(idx));
    chk({tag, ".load.ld"},  32'(bus.ld_shiftreg), 32'h1);
    chk({tag, ".load.val"}, 32'(bus.valid), 32'h0);
    bus.req = req_after;
    for (int c = 1; c <= c_bits * c_spb; c++) begin
      tick();
      chk({tag, ".send.val"},   32'(bus.valid), 32'h1);
      chk({tag, ".send.gnt"},   32'(bus.gnt), 32'(oh));
      chk({tag, ".send.sel"},   32'(bus.sel), 32'(idx));
      chk({tag, ".send.ld"},    32'(bus.ld_shiftreg), 32'h0);
      chk({tag, ".send.shift"}, 32'(bus.shift_en), 32'((c % c_spb) == 0));
      chk({tag, ".send.done"},  32'(bus.done), (c == c_bits * c_spb) ? 32'(oh) : 32'h0);
    end
    for (int g = 0; g < c_gap; g++) begin
      tick();
      chk({tag, ".gap.busy"}, 32'(bus.busy), 32'h1);
      chk_quiet({tag, ".gap"});
    end
    tick();
    chk({tag, ".idle.busy"}, 32'(bus.busy), 32'h0);
    chk_quiet({tag, ".idle"});
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    reset   = 1'b0;
    bus.req = 4'b1111;

    // Reset held with every source requesting.
    for (int r = 0; r < 2; r++) begin
      tick();
      chk("rst.busy", 32'(bus.busy), 32'h0);
      chk_quiet("rst");
    end

    // Single request.
    reset   = 1'b1;
    bus.req = 4'b0100;
    expect_msg("single", 2, 4'b0000);

    // Request dropped right after grant still completes.
    bus.req = 4'b0010;
    expect_msg("drop", 1, 4'b0000);

    // Reset in the middle of SEND.
    bus.req = 4'b0001;
    tick();
    chk("mid.load.gnt", 32'(bus.gnt), 32'h1);
    bus.req = 4'b0000;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("mid.send.val", 32'(bus.valid), 32'h1);
    end
    reset = 1'b0;
    tick();
    chk("mid.rst.busy", 32'(bus.busy), 32'h0);
    chk_quiet("mid.rst");
    reset   = 1'b1;
    bus.req = 4'b1000;
    expect_msg("after_rst", 3, 4'b0000);

    // All sources requesting after reset.
    reset   = 1'b0;
    bus.req = 4'b0000;
    tick();
    reset   = 1'b1;
    bus.req = 4'b1111;
    expect_msg("all0", 0, 4'b1111);
    expect_msg("all1", 1, 4'b1111);
    expect_msg("all2", 2, 4'b1111);
    expect_msg("all3", 3, 4'b1111);
    expect_msg("all0b", 0, 4'b0000);

    // Two sources alternating.
    reset = 1'b0;
    tick();
    reset   = 1'b1;
    bus.req = 4'b0101;
    expect_msg("rr0", 0, 4'b0101);
    expect_msg("rr2", 2, 4'b0101);
    expect_msg("rr0b", 0, 4'b0101);
    expect_msg("rr2b", 2, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
